// File: rtl/rom_arbiter_if.sv
// Request/response bundle for the two ROM client ports (A = fetch, B = data).
// The master drives requests and response acceptance; the slave is the arbiter.
interface rom_arbiter_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32
);
  logic                  a_req_valid;
  logic [addr_width-1:0] a_req_addr;
  logic                  a_req_ready;
  logic                  a_rsp_valid;
  logic                  a_rsp_ready;
  logic [data_width-1:0] a_rsp_data;
  logic                  a_rsp_err;

  logic                  b_req_valid;
  logic [addr_width-1:0] b_req_addr;
  logic                  b_req_ready;
  logic                  b_rsp_valid;
  logic                  b_rsp_ready;
  logic [data_width-1:0] b_rsp_data;
  logic                  b_rsp_err;

  modport master (
    output a_req_valid, a_req_addr, a_rsp_ready,
    output b_req_valid, b_req_addr, b_rsp_ready,
    input  a_req_ready, a_rsp_valid, a_rsp_data, a_rsp_err,
    input  b_req_ready, b_rsp_valid, b_rsp_data, b_rsp_err
  );

  modport slave (
    input  a_req_valid, a_req_addr, a_rsp_ready,
    input  b_req_valid, b_req_addr, b_rsp_ready,
    output a_req_ready, a_rsp_valid, a_rsp_data, a_rsp_err,
    output b_req_ready, b_rsp_valid, b_rsp_data, b_rsp_err
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous ROM.
// Each port has one outstanding read; out-of-range reads answer with err and zero data.
module rom_arbiter #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int rom_bytes  = 8192
) (
  input  logic                  rom_clk,
  input  logic                  rom_rst_n,
  rom_arbiter_if.slave          bus,
  output logic [addr_width-1:0] rom_addr,
  output logic                  rom_en,
  output logic                  rom_rst,
  input  logic [data_width-1:0] rom_din
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INFLIGHT = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  localparam logic [addr_width:0] c_word_bytes = (addr_width + 1)'(data_width / 8);
  localparam logic [addr_width:0] c_rom_bytes  = (addr_width + 1)'(rom_bytes);

  // One extra bit keeps addresses near the top of the space from wrapping into range.
  function automatic logic f_in_range(input logic [addr_width-1:0] addr);
    logic [addr_width:0] w_end;
    w_end = {1'b0, addr} + c_word_bytes;
    return (w_end <= c_rom_bytes);
  endfunction

  state_t                r_state    [2];
  logic                  r_err_pend [2];
  logic [data_width-1:0] r_rsp_data [2];
  logic [1:0]            r_rsp_err;
  logic                  r_rr_b;

  logic [1:0]            w_req_valid;
  logic [1:0]            w_rsp_ready;
  logic [addr_width-1:0] w_req_addr [2];
  logic [1:0]            w_in_range;
  logic [1:0]            w_elig;
  logic [1:0]            w_ready;
  logic [1:0]            w_grant;
  logic [addr_width-1:0] w_gnt_addr;
  logic                  w_gnt_in_range;

  assign w_req_valid   = {bus.b_req_valid, bus.a_req_valid};
  assign w_rsp_ready   = {bus.b_rsp_ready, bus.a_rsp_ready};
  assign w_req_addr[0] = bus.a_req_addr;
  assign w_req_addr[1] = bus.b_req_addr;

  assign rom_rst = ~rom_rst_n;

  assign bus.a_req_ready = w_ready[0];
  assign bus.b_req_ready = w_ready[1];
  assign bus.a_rsp_valid = (r_state[0] == ST_RESP);
  assign bus.b_rsp_valid = (r_state[1] == ST_RESP);
  assign bus.a_rsp_data  = r_rsp_data[0];
  assign bus.b_rsp_data  = r_rsp_data[1];
  assign bus.a_rsp_err   = r_rsp_err[0];
  assign bus.b_rsp_err   = r_rsp_err[1];

  // Eligibility, round-robin grant and the ROM command for the granted port.
  always_comb begin
    w_in_range     = 2'b00;
    w_elig         = 2'b00;
    w_ready        = 2'b00;
    w_grant        = 2'b00;
    w_gnt_addr     = '0;
    w_gnt_in_range = 1'b0;
    rom_en         = 1'b0;
    rom_addr       = '0;
    // A response retiring this cycle frees its port, so back-to-back grants can alternate.
    for (int i = 0; i < 2; i++) begin
      w_in_range[i] = f_in_range(w_req_addr[i]);
      w_elig[i]     = rom_rst_n && ((r_state[i] == ST_IDLE) ||
                                    ((r_state[i] == ST_RESP) && w_rsp_ready[i]));
    end
    w_ready[0] = w_elig[0] && (!(w_req_valid[1] && w_elig[1]) || !r_rr_b);
    w_ready[1] = w_elig[1] && (!(w_req_valid[0] && w_elig[0]) ||  r_rr_b);
    w_grant    = w_req_valid & w_ready;
    if (w_grant[1]) begin
      w_gnt_addr     = w_req_addr[1];
      w_gnt_in_range = w_in_range[1];
    end else begin
      w_gnt_addr     = w_req_addr[0];
      w_gnt_in_range = w_in_range[0];
    end
    rom_en = (|w_grant) && w_gnt_in_range;
    if (rom_en) begin
      rom_addr = w_gnt_addr;
    end else begin
      rom_addr = '0;
    end
  end

  // Per-port read state machines, response registers and round-robin pointer.
  always_ff @(posedge rom_clk or negedge rom_rst_n) begin
    if (!rom_rst_n) begin
      r_rr_b    <= 1'b0;
      r_rsp_err <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_state[i]    <= ST_IDLE;
        r_err_pend[i] <= 1'b0;
        r_rsp_data[i] <= '0;
      end
    end else begin
      if (|w_grant) begin
        r_rr_b <= w_grant[0];
      end else begin
        r_rr_b <= r_rr_b;
      end
      for (int i = 0; i < 2; i++) begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_grant[i]) begin
              r_state[i]    <= ST_INFLIGHT;
              r_err_pend[i] <= ~w_in_range[i];
            end else begin
              r_state[i] <= ST_IDLE;
            end
          end
          ST_INFLIGHT: begin
            r_state[i]    <= ST_RESP;
            r_rsp_err[i]  <= r_err_pend[i];
            r_rsp_data[i] <= r_err_pend[i] ? '0 : rom_din;
          end
          ST_RESP: begin
            if (w_grant[i]) begin
              r_state[i]    <= ST_INFLIGHT;
              r_err_pend[i] <= ~w_in_range[i];
            end else if (w_rsp_ready[i]) begin
              r_state[i] <= ST_IDLE;
            end else begin
              r_state[i] <= ST_RESP;
            end
          end
          default: begin
            r_state[i] <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a cycle-count reference model of the two ports.
module tb_rom_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RB = 8192;

  logic          rom_clk   = 1'b0;
  logic          rom_rst_n = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          rom_en;
  logic          rom_rst;
  logic [DW-1:0] rom_din = '0;

  rom_arbiter_if #(.addr_width(AW), .data_width(DW)) ifc ();

  rom_arbiter #(.addr_width(AW), .data_width(DW), .rom_bytes(RB)) dut (
    .rom_clk   (rom_clk),
    .rom_rst_n (rom_rst_n),
    .bus       (ifc),
    .rom_addr  (rom_addr),
    .rom_en    (rom_en),
    .rom_rst   (rom_rst),
    .rom_din   (rom_din)
  );

  always #5 rom_clk = ~rom_clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a * 32'h0100_0193 + 32'h1234_5678;
  endfunction

  // Synchronous ROM: data for the enabled address appears one cycle later.
  always @(posedge rom_clk) begin
    if (rom_en) rom_din <= rom_word(rom_addr);
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: outstanding flag, grant cycle and expected response per port.
  bit          m_out  [2];
  int          m_gcyc [2];
  logic [31:0] m_data [2];
  bit          m_err  [2];
  int          m_last = 1;
  int          cyc = 0;
  int          fill_mode = 0;
  int          rom_en_seen = 0;

  function automatic bit m_in_range(input logic [31:0] a);
    return (longint'(a) + 64'd4) <= longint'(RB);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_valid(input int p);
    return (p == 0) ? ifc.a_req_valid : ifc.b_req_valid;
  endfunction
  function automatic logic [31:0] get_addr(input int p);
    return (p == 0) ? ifc.a_req_addr : ifc.b_req_addr;
  endfunction
  function automatic logic get_rsp_ready(input int p);
    return (p == 0) ? ifc.a_rsp_ready : ifc.b_rsp_ready;
  endfunction

  task automatic set_req(input int p, input logic v, input logic [31:0] a);
    if (p == 0) begin ifc.a_req_valid = v; ifc.a_req_addr = a; end
    else        begin ifc.b_req_valid = v; ifc.b_req_addr = a; end
  endtask
  task automatic set_rsp_ready(input int p, input logic r);
    if (p == 0) ifc.a_rsp_ready = r;
    else        ifc.b_rsp_ready = r;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    if (sel == 1) return 32'd8186 + 32'($urandom_range(0, 7));
    return 32'($urandom_range(0, 8191));
  endfunction

  // One clock: check at the falling edge, advance the model at the rising edge, then drive.
  task automatic cycle();
    bit rv [2];
    bit el [2];
    bit vl [2];
    bit exp_rdy [2];
    int g;
    logic [31:0] ga;
    bit ginr;
    @(negedge rom_clk);
    g = -1;
    for (int p = 0; p < 2; p++) begin
      rv[p] = rom_rst_n && m_out[p] && (cyc >= m_gcyc[p] + 2);
      el[p] = rom_rst_n && (!m_out[p] || (rv[p] && get_rsp_ready(p)));
      vl[p] = get_valid(p) && el[p];
    end
    if (vl[0] && vl[1]) g = (m_last == 0) ? 1 : 0;
    else if (vl[0])     g = 0;
    else if (vl[1])     g = 1;
    for (int p = 0; p < 2; p++) exp_rdy[p] = el[p] && (!vl[1-p] || (m_last != p));
    ga   = (g >= 0) ? get_addr(g) : 32'd0;
    ginr = (g >= 0) && m_in_range(ga);

    chk("a_req_ready", 64'(ifc.a_req_ready), 64'(exp_rdy[0]));
    chk("b_req_ready", 64'(ifc.b_req_ready), 64'(exp_rdy[1]));
    chk("rom_en", 64'(rom_en), 64'(ginr));
    chk("rom_addr", 64'(rom_addr), ginr ? 64'(ga) : 64'd0);
    chk("rom_rst", 64'(rom_rst), 64'(!rom_rst_n));
    chk("a_rsp_valid", 64'(ifc.a_rsp_valid), 64'(rv[0]));
    chk("b_rsp_valid", 64'(ifc.b_rsp_valid), 64'(rv[1]));
    if (rv[0] || !rom_rst_n) begin
      chk("a_rsp_data", 64'(ifc.a_rsp_data), rv[0] ? 64'(m_data[0]) : 64'd0);
      chk("a_rsp_err", 64'(ifc.a_rsp_err), rv[0] ? 64'(m_err[0]) : 64'd0);
    end
    if (rv[1] || !rom_rst_n) begin
      chk("b_rsp_data", 64'(ifc.b_rsp_data), rv[1] ? 64'(m_data[1]) : 64'd0);
      chk("b_rsp_err", 64'(ifc.b_rsp_err), rv[1] ? 64'(m_err[1]) : 64'd0);
    end
    if (rom_en) rom_en_seen++;

    @(posedge rom_clk);
    if (!rom_rst_n) begin
      for (int p = 0; p < 2; p++) m_out[p] = 1'b0;
      m_last = 1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rv[p] && get_rsp_ready(p)) m_out[p] = 1'b0;
      end
      if (g >= 0) begin
        m_out[g]  = 1'b1;
        m_gcyc[g] = cyc;
        m_err[g]  = !ginr;
        m_data[g] = ginr ? rom_word(ga) : 32'd0;
        m_last    = g;
      end
    end
    cyc++;
    #1;
    for (int p = 0; p < 2; p++) begin
      if (g == p) begin
        case (fill_mode)
          0:       set_req(p, 1'b0, get_addr(p));
          1:       set_req(p, 1'b1, get_addr(p) + 32'd4);
          default: set_req(p, 1'b0, get_addr(p));
        endcase
      end
      if (fill_mode == 2) begin
        if (!get_valid(p) && ($urandom_range(0, 1) == 1)) set_req(p, 1'b1, rand_addr());
        set_rsp_ready(p, $urandom_range(0, 3) != 0);
      end
    end
  endtask

  task automatic do_reset(input int n);
    rom_rst_n = 1'b0;
    repeat (n) cycle();
    rom_rst_n = 1'b1;
  endtask

  initial begin
    ifc.a_req_valid = 1'b0; ifc.a_req_addr = '0; ifc.a_rsp_ready = 1'b1;
    ifc.b_req_valid = 1'b0; ifc.b_req_addr = '0; ifc.b_rsp_ready = 1'b1;

    // Reset state, including a request held during reset that must not be accepted.
    cycle();
    set_req(0, 1'b1, 32'h10);
    do_reset(2);
    set_req(0, 1'b0, 32'h0);
    cycle();

    // Single read from port A at 0x10.
    fill_mode = 0;
    set_req(0, 1'b1, 32'h10);
    repeat (4) cycle();

    // Both ports from reset: A first, then strict alternation with rom_en every cycle.
    do_reset(1);
    fill_mode = 1;
    set_req(0, 1'b1, 32'h100);
    set_req(1, 1'b1, 32'h800);
    rom_en_seen = 0;
    repeat (8) cycle();
    chk("alternation_rom_en_count", 64'(rom_en_seen), 64'd8);
    fill_mode = 0;
    set_req(0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0);
    repeat (3) cycle();

    // Range boundaries on port B.
    set_req(1, 1'b1, 32'd8190);     repeat (3) cycle();
    set_req(1, 1'b1, 32'hFFFF_FFFE); repeat (3) cycle();
    set_req(1, 1'b1, 32'd8188);     repeat (3) cycle();
    set_req(1, 1'b1, 32'd8189);     repeat (3) cycle();

    // A's response back-pressured while B keeps being served.
    fill_mode = 1;
    set_rsp_ready(0, 1'b0);
    set_req(0, 1'b1, 32'h40);
    set_req(1, 1'b1, 32'h200);
    repeat (8) cycle();
    set_rsp_ready(0, 1'b1);
    repeat (3) cycle();
    fill_mode = 0;
    set_req(0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0);
    repeat (4) cycle();

    // Reset pulse the cycle after an A grant discards the read.
    set_req(0, 1'b1, 32'h20);
    cycle();
    rom_rst_n = 1'b0;
    #1;
    chk("rst_async_a_rsp_valid", 64'(ifc.a_rsp_valid), 64'd0);
    chk("rst_async_rom_en", 64'(rom_en), 64'd0);
    chk("rst_async_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_async_rom_rst", 64'(rom_rst), 64'd1);
    chk("rst_async_a_rsp_data", 64'(ifc.a_rsp_data), 64'd0);
    cycle();
    rom_rst_n = 1'b1;
    repeat (4) cycle();

    // Random traffic.
    fill_mode = 2;
    repeat (400) cycle();
    fill_mode = 0;
    set_req(0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0);
    set_rsp_ready(0, 1'b1);
    set_rsp_ready(1, 1'b1);
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
